// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: start control, downstream stall/redirect, ROM port and issue register outputs.
// The fetch unit connects through the slave modport; its environment through master.
interface instr_fetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               Start;
    logic [PC_W-1:0]    StartAddr;
    logic               Stall;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchTarget;
    logic [PC_W-1:0]    ImemAddr;
    logic [INSTR_W-1:0] ImemData;
    logic               InstrValid;
    logic [INSTR_W-1:0] InstrOut;
    logic [PC_W-1:0]    PcOut;
    logic [3:0]         Opcode;
    logic               Illegal;
    logic               Done;
    logic [CNT_W-1:0]   InstrCount;

    modport master (
        output Start, StartAddr, Stall, BranchTaken, BranchTarget, ImemData,
        input  ImemAddr, InstrValid, InstrOut, PcOut, Opcode, Illegal, Done, InstrCount
    );

    modport slave (
        input  Start, StartAddr, Stall, BranchTaken, BranchTarget, ImemData,
        output ImemAddr, InstrValid, InstrOut, PcOut, Opcode, Illegal, Done, InstrCount
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, combinational ROM read, one-entry issue register with stall,
// taken-branch redirect and HALT detection.
module instr_fetch #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    instr_fetch_if.slave  bus
);
    localparam logic [3:0] OP_ILLEGAL = 4'b1110;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [PC_W-1:0]    pc_reg,     pc_next;
    logic [INSTR_W-1:0] instr_reg,  instr_next;
    logic [PC_W-1:0]    pcout_reg,  pcout_next;
    logic               valid_reg,  valid_next;
    logic               done_reg,   done_next;
    logic [CNT_W-1:0]   count_reg,  count_next;

    logic               fetch_is_halt;

    assign fetch_is_halt = (bus.ImemData[INSTR_W-1 -: 4] == OP_HALT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            pcout_reg <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pcout_reg <= pcout_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pcout_next = pcout_reg;
        valid_next = valid_reg;
        done_next  = done_reg;
        count_next = count_reg;

        unique case (state_reg)
            IDLE, HALTED: begin
                if (bus.Start) begin
                    state_next = RUN;
                    pc_next    = bus.StartAddr;
                    valid_next = 1'b0;
                    done_next  = 1'b0;
                    count_next = '0;
                end
            end
            RUN: begin
                // Redirect beats stall and HALT: the word at the current PC is wrong-path.
                if (bus.BranchTaken) begin
                    pc_next    = bus.BranchTarget;
                    valid_next = 1'b0;
                end else if (bus.Stall) begin
                    state_next = RUN;
                end else if (fetch_is_halt) begin
                    state_next = HALTED;
                    done_next  = 1'b1;
                    valid_next = 1'b0;
                end else begin
                    instr_next = bus.ImemData;
                    pcout_next = pc_reg;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + PC_W'(1);
                    if (count_reg != {CNT_W{1'b1}}) begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ImemAddr   = pc_reg;
    assign bus.InstrValid = valid_reg;
    assign bus.InstrOut   = instr_reg;
    assign bus.PcOut      = pcout_reg;
    assign bus.Opcode     = instr_reg[INSTR_W-1 -: 4];
    assign bus.Illegal    = valid_reg && (instr_reg[INSTR_W-1 -: 4] == OP_ILLEGAL);
    assign bus.Done       = done_reg;
    assign bus.InstrCount = count_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed test-plan steps followed by randomized start/stall/branch/reset traffic,
// every edge compared against a cycle model of the fetch rules.
module tb_instr_fetch;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [3:0] K_LSH = 4'b0000;
    localparam logic [3:0] K_OR  = 4'b0011;
    localparam logic [3:0] K_ADD = 4'b1011;
    localparam logic [3:0] K_BNZ = 4'b1000;
    localparam logic [3:0] K_ILL = 4'b1110;
    localparam logic [3:0] K_HLT = 4'b1111;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];
    assign bus.ImemData = rom[bus.ImemAddr];

    // Reference model state
    bit                 m_run;
    logic [PC_W-1:0]    m_pc;
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_pcout;
    logic               m_valid;
    logic               m_done;
    int unsigned        m_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = '0; m_instr = '0; m_pcout = '0;
        m_valid = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [INSTR_W-1:0] word;
        word = rom[m_pc];
        if (!Reset_n) begin
            model_reset();
        end else if (!m_run) begin
            if (bus.Start) begin
                m_run = 1; m_pc = bus.StartAddr; m_valid = 0; m_done = 0; m_cnt = 0;
            end
        end else if (bus.BranchTaken) begin
            m_pc = bus.BranchTarget; m_valid = 0;
        end else if (bus.Stall) begin
            m_run = 1;
        end else if (word[INSTR_W-1 -: 4] == K_HLT) begin
            m_run = 0; m_done = 1; m_valid = 0;
        end else begin
            m_instr = word; m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all(input string where);
        logic [3:0] exp_op;
        exp_op = m_instr[INSTR_W-1 -: 4];
        chk({where, ".ImemAddr"},   32'(bus.ImemAddr),   32'(m_pc));
        chk({where, ".InstrValid"}, 32'(bus.InstrValid), 32'(m_valid));
        chk({where, ".InstrOut"},   32'(bus.InstrOut),   32'(m_instr));
        chk({where, ".PcOut"},      32'(bus.PcOut),      32'(m_pcout));
        chk({where, ".Opcode"},     32'(bus.Opcode),     32'(exp_op));
        chk({where, ".Illegal"},    32'(bus.Illegal),    32'(m_valid && exp_op == K_ILL));
        chk({where, ".Done"},       32'(bus.Done),       32'(m_done));
        chk({where, ".InstrCount"}, 32'(bus.InstrCount), m_cnt);
    endtask

    int cyc = 0;
    task automatic tick(input string where);
        @(posedge Clk);
        model_edge();
        #1;
        cyc++;
        check_all(where);
        $display("cyc=%0d %s valid=%0b pc_out=%03h instr=%03h done=%0b cnt=%0d",
                 cyc, where, bus.InstrValid, bus.PcOut, bus.InstrOut, bus.Done, bus.InstrCount);
    endtask

    task automatic start_at(input logic [PC_W-1:0] addr, input string where);
        bus.Start = 1'b1; bus.StartAddr = addr;
        tick(where);
        bus.Start = 1'b0;
    endtask

    function automatic logic [INSTR_W-1:0] op(input logic [3:0] o, input logic [4:0] lo);
        return {o, lo};
    endfunction

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = op(K_ADD, 5'(i));
        bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0;
        bus.BranchTaken = 0; bus.BranchTarget = '0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        Reset_n = 1'b1;

        // Straight line ADD, LSH, OR, HALT
        rom[0] = op(K_ADD, 5'h01); rom[1] = op(K_LSH, 5'h02);
        rom[2] = op(K_OR,  5'h03); rom[3] = op(K_HLT, 5'h00);
        start_at(10'h000, "t1_start");
        tick("t1_i0"); chk("t1_pc0", 32'(bus.PcOut), 0); chk("t1_op0", 32'(bus.Opcode), 32'(K_ADD));
        tick("t1_i1"); chk("t1_pc1", 32'(bus.PcOut), 1); chk("t1_op1", 32'(bus.Opcode), 32'(K_LSH));
        tick("t1_i2"); chk("t1_pc2", 32'(bus.PcOut), 2); chk("t1_op2", 32'(bus.Opcode), 32'(K_OR));
        tick("t1_halt"); chk("t1_done", 32'(bus.Done), 1); chk("t1_cnt", 32'(bus.InstrCount), 3);

        // Stall while PcOut=1
        rom[3] = op(K_ADD, 5'h04); rom[4] = op(K_HLT, 5'h00);
        start_at(10'h000, "t2_start");
        tick("t2_i0");
        tick("t2_i1");
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("t2_stall");
            chk("t2_hold_pc", 32'(bus.PcOut), 1);
            chk("t2_hold_cnt", 32'(bus.InstrCount), 2);
        end
        bus.Stall = 1'b0;
        tick("t2_resume"); chk("t2_pc2", 32'(bus.PcOut), 2); chk("t2_cnt3", 32'(bus.InstrCount), 3);
        tick("t2_i3"); tick("t2_halt");

        // Taken branch beats HALT
        rom[5] = op(K_BNZ, 5'h07); rom[6] = op(K_HLT, 5'h00);
        rom[10'h020] = op(K_OR, 5'h09); rom[10'h021] = op(K_HLT, 5'h00);
        start_at(10'h005, "t3_start");
        tick("t3_bnz"); chk("t3_pc5", 32'(bus.PcOut), 5);
        bus.BranchTaken = 1'b1; bus.BranchTarget = 10'h020;
        tick("t3_bubble"); chk("t3_nodone", 32'(bus.Done), 0); chk("t3_bubble_v", 32'(bus.InstrValid), 0);
        bus.BranchTaken = 1'b0;
        tick("t3_target"); chk("t3_pc20", 32'(bus.PcOut), 32'h020);
        tick("t3_halt");

        // Wrap, then branch together with stall
        rom[10'h3FE] = op(K_ADD, 5'h11); rom[10'h3FF] = op(K_LSH, 5'h12);
        rom[0] = op(K_OR, 5'h13); rom[1] = op(K_ADD, 5'h14);
        rom[10'h010] = op(K_LSH, 5'h15); rom[10'h011] = op(K_HLT, 5'h00);
        start_at(10'h3FE, "t4_start");
        tick("t4_3fe"); chk("t4_pc3fe", 32'(bus.PcOut), 32'h3FE);
        tick("t4_3ff"); chk("t4_pc3ff", 32'(bus.PcOut), 32'h3FF);
        tick("t4_000"); chk("t4_pc000", 32'(bus.PcOut), 32'h000);
        bus.Stall = 1'b1; bus.BranchTaken = 1'b1; bus.BranchTarget = 10'h010;
        tick("t4_bubble");
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0;
        tick("t4_target"); chk("t4_pc010", 32'(bus.PcOut), 32'h010);
        tick("t4_halt");

        // Illegal issued and counted, then restart at 0x100
        rom[0] = op(K_ILL, 5'h1F); rom[1] = op(K_HLT, 5'h00);
        rom[10'h100] = op(K_ADD, 5'h05); rom[10'h101] = op(K_OR, 5'h06);
        start_at(10'h000, "t5_start");
        tick("t5_ill"); chk("t5_illegal", 32'(bus.Illegal), 1); chk("t5_cnt", 32'(bus.InstrCount), 1);
        tick("t5_halt"); chk("t5_ill_clear", 32'(bus.Illegal), 0);
        start_at(10'h100, "t5_restart"); chk("t5_done0", 32'(bus.Done), 0); chk("t5_cnt0", 32'(bus.InstrCount), 0);
        tick("t5_i100"); chk("t5_pc100", 32'(bus.PcOut), 32'h100);

        // Asynchronous reset mid-run; Start ignored while held
        tick("t6_i101");
        #2 Reset_n = 1'b0;
        model_reset();
        #1 check_all("t6_async");
        chk("t6_valid0", 32'(bus.InstrValid), 0);
        bus.Start = 1'b1; bus.StartAddr = 10'h055;
        tick("t6_start_ignored");
        bus.Start = 1'b0;
        #3 Reset_n = 1'b1;
        tick("t6_idle");

        // Randomized traffic
        for (int i = 0; i < (1 << PC_W); i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r == 0)      rom[i] = op(K_HLT, 5'($urandom));
            else if (r <= 2) rom[i] = op(K_ILL, 5'($urandom));
            else             rom[i] = op(4'($urandom_range(0, 13)), 5'($urandom));
        end
        for (int i = 0; i < 600; i++) begin
            bus.Start        = ($urandom_range(0, 7) == 0);
            bus.StartAddr    = PC_W'($urandom);
            bus.Stall        = ($urandom_range(0, 3) == 0);
            bus.BranchTaken  = ($urandom_range(0, 5) == 0);
            bus.BranchTarget = PC_W'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 Reset_n = 1'b0;
                model_reset();
                #1 check_all("rnd_async");
                #1 Reset_n = 1'b1;
            end
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the basic processor. Holds the program counter and reads 9-bit instructions from the combinational instruction ROM. Registers each instruction with its PC into a one-entry issue register for the decode/ALU stage. It honours downstream stalls, redirects on taken BNZ branches, and stops at the HALT encoding. Opcode field encodings match the `definitions` package (kLSH..kNEQ); 4'b1110 is illegal and 4'b1111 is HALT.

## Interface
- PC_W, 10, program counter / ROM address width
- INSTR_W, 9, instruction width; opcode = bits [INSTR_W-1 -: 4]
- CNT_W, 16, issued-instruction counter width

- Clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin execution at StartAddr; honoured only in IDLE or HALTED
- StartAddr  in  PC_W  first instruction address
- Stall  in  1  downstream cannot accept; hold issue register
- BranchTaken  in  1  downstream resolved the issued BNZ as taken
- BranchTarget  in  PC_W  redirect address, valid with BranchTaken
- ImemAddr  out  PC_W  ROM address (= PC, combinational)
- ImemData  in  INSTR_W  ROM data for ImemAddr, same cycle
- InstrValid  out  1  issue register holds a real instruction
- InstrOut  out  INSTR_W  issued instruction
- PcOut  out  PC_W  PC of InstrOut
- Opcode  out  4  InstrOut opcode field
- Illegal  out  1  InstrValid & Opcode==4'b1110 (combinational)
- Done  out  1  halted; held until next Start
- InstrCount  out  CNT_W  instructions issued since last Start

## Operation
- States: IDLE, RUN, HALTED. Reset_n low → IDLE, PC=0, InstrOut=0, PcOut=0, InstrValid=0, Done=0, InstrCount=0.
- IDLE/HALTED + Start: PC←StartAddr, InstrValid←0, Done←0, InstrCount←0, → RUN. Other inputs ignored in IDLE/HALTED.
- RUN, per edge, priority order:
  1. BranchTaken: PC←BranchTarget, InstrValid←0 (wrong-path fetch dropped), counter unchanged. Overrides Stall and HALT detection.
  2. Stall: PC, InstrOut, PcOut, InstrValid, InstrCount all hold.
  3. ImemData opcode==4'b1111: → HALTED, Done←1, InstrValid←0, PC holds. HALT is not issued or counted.
  4. Otherwise: InstrOut←ImemData, PcOut←PC, InstrValid←1, PC←PC+1, InstrCount←InstrCount+1.
- Start during RUN is ignored.
- Illegal instructions are issued and counted normally; only the Illegal flag distinguishes them.
- PC increments modulo 2^PC_W (0x3FF → 0x000). InstrCount saturates at all-ones.
- BranchTaken/Stall are don't-care outside RUN.
- Reset_n asserted in any state forces the reset values immediately (asynchronously), including mid-stall or mid-branch.

## Timing
- Start sampled at edge t → RUN with PC=StartAddr after t. First instruction valid after t+1. Sustained throughput 1 instruction/cycle.
- Taken branch: one bubble. BranchTaken at edge t gives InstrValid=0 for cycle t..t+1, and ROM[BranchTarget] is valid after t+1.
- Stall: outputs frozen the same edge Stall is sampled high. Issue resumes on the first edge with Stall low.
- HALT at PC=h sampled at edge t: Done=1 and InstrValid=0 from t onward. The last issued instruction is the one at h-1 (or the branch path).
- Illegal and Opcode are combinational from the issue register; there is no extra latency.

## Test plan
- Reset/straight line: ROM[0..3]={ADD,LSH,OR,HALT}, Start with StartAddr=0 → PcOut 0,1,2 valid on consecutive cycles, Opcodes 4'b1011/0000/0011; Done=1 one cycle later; InstrCount=3.
- Stall: assert Stall 3 cycles while PcOut=1 → InstrOut/PcOut/InstrCount frozen; PcOut=2 on the first edge after Stall drops; no instruction lost or duplicated.
- Taken branch vs HALT: ROM[5]=BNZ, ROM[6]=HALT, BranchTaken with target 0x020 while PcOut=5 → HALT not taken, Done stays 0; one bubble; PcOut=0x020 next.
- Branch during stall + wrap: start at 0x3FE → PcOut 0x3FE, 0x3FF, 0x000; assert Stall and BranchTaken (target 0x010) together → redirect wins, PcOut=0x010 after one bubble.
- Illegal/restart: ROM[0]=4'b1110 encoding → Illegal=1 for exactly the cycle it is valid, counted; after HALT, Start with StartAddr=0x100 → Done clears, InstrCount resets to 0, fetch resumes at 0x100.
- Async reset mid-run: drop Reset_n between edges while InstrValid=1 → all outputs return to reset values immediately; Start ignored until Reset_n high.
